hornet_port_ctl: RTL and testbench

HORNET_PORT_CTL -- requirements
Module: hornet_port_ctl

---
 rtl/hornet_pkg.sv | 24 ++
 rtl/hornet_rr_arb4.sv | 32 +++
 rtl/hornet_port_ctl.sv | 121 ++++++++++++
 tb/tb_hornet_port_ctl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/hornet_pkg.sv
// hornet_pkg: shared types and constants for the hornet port controller.
//   WORD_W   - width of a port/core data word
//   port_e   - port index, bit order {e,w,s,n} = [3:0]
//   state_e  - controller FSM states
package hornet_pkg;

  localparam int WORD_W    = 18;
  localparam int NUM_PORTS = 4;

  typedef enum logic [1:0] {
    PORT_N = 2'd0,
    PORT_S = 2'd1,
    PORT_W = 2'd2,
    PORT_E = 2'd3
  } port_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

endpackage

// File: rtl/hornet_rr_arb4.sv
// hornet_rr_arb4: combinational 4-way round-robin picker.
//   hit   - per-port request vector
//   ptr   - last granted port; search starts at ptr+1 and wraps (n after e)
//   grant - index of the chosen port (meaningful only when valid)
//   valid - at least one hit bit set
module hornet_rr_arb4
  import hornet_pkg::*;
(
  input  logic [3:0] hit,
  input  logic [1:0] ptr,
  output logic [1:0] grant,
  output logic       valid
);

  logic [1:0] idx;

  // Walk from the farthest candidate (ptr itself) to the nearest (ptr+1);
  // the last match written wins, so the nearest hit after ptr is granted.
  always_comb begin
    grant = ptr;
    valid = 1'b0;
    idx   = ptr;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      idx = ptr + i[1:0];
      if (hit[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hornet_port_ctl.sv
// hornet_port_ctl: single-transaction bridge between a core and four
// neighbour ports (n,s,w,e).
//   clk, reset            - clock, synchronous active-high reset
//   core_req/we/mask/wdat - transaction start strobe and its parameters
//   core_rdat             - read word, held until the next completion
//   core_done, core_busy  - completion pulse, transaction in flight
//   t_com_dat/req/ack     - inbound (read) handshake per port
//   i_com_dat/req/ack     - outbound (write) handshake, shared data word
module hornet_port_ctl
  import hornet_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   core_req,
  input  logic                   core_we,
  input  logic [3:0]             core_mask,
  input  logic [WORD_W-1:0]      core_wdat,
  output logic [WORD_W-1:0]      core_rdat,
  output logic                   core_done,
  output logic                   core_busy,
  input  logic [3:0][WORD_W-1:0] t_com_dat,
  input  logic [3:0]             t_com_req,
  output logic [3:0]             t_com_ack,
  output logic [WORD_W-1:0]      i_com_dat,
  output logic [3:0]             i_com_req,
  input  logic [3:0]             i_com_ack
);

  state_e            state;
  port_e             ptr;
  logic [3:0]        mask_q;
  logic [WORD_W-1:0] wdat_q;

  logic [3:0]        hit;
  logic [1:0]        arb_grant;
  logic              arb_valid;

  assign hit = t_com_req & mask_q;

  hornet_rr_arb4 u_arb (
    .hit   (hit),
    .ptr   (ptr),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  // The direction of a transaction is carried by the wait state itself,
  // so only mask and write data need holding registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= PORT_E;
      mask_q    <= '0;
      wdat_q    <= '0;
      core_rdat <= '0;
      core_done <= 1'b0;
      core_busy <= 1'b0;
    end else begin
      core_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (core_req) begin
            mask_q    <= core_mask;
            wdat_q    <= core_wdat;
            core_busy <= 1'b1;
            if (core_mask == 4'b0000) begin
              // Empty mask: nothing to wait for. RESP spends one extra
              // cycle before pulsing done so the completion latency matches
              // a transaction whose port is already ready.
              state <= ST_RESP;
              if (!core_we) core_rdat <= '0;
            end else if (core_we) begin
              state <= ST_WR_WAIT;
            end else begin
              state <= ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          if (arb_valid) begin
            core_rdat <= t_com_dat[arb_grant];
            ptr       <= port_e'(arb_grant);
            core_done <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_WR_WAIT: begin
          if ((i_com_ack & mask_q) != 4'b0000) begin
            core_done <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (core_done) begin
            core_busy <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            core_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Port handshakes decode the state register directly; gating with reset
  // drops them in the very cycle reset is applied, not one edge later.
  always_comb begin
    t_com_ack = 4'b0000;
    i_com_req = 4'b0000;
    i_com_dat = '0;
    if (!reset) begin
      if (state == ST_RD_WAIT && arb_valid) t_com_ack = 4'b0001 << arb_grant;
      if (state == ST_WR_WAIT) begin
        i_com_req = mask_q;
        i_com_dat = wdat_q;
      end
    end
  end

endmodule

// File: tb/tb_hornet_port_ctl.sv
module tb_hornet_port_ctl;
  import hornet_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   core_req;
  logic                   core_we;
  logic [3:0]             core_mask;
  logic [WORD_W-1:0]      core_wdat;
  logic [WORD_W-1:0]      core_rdat;
  logic                   core_done;
  logic                   core_busy;
  logic [3:0][WORD_W-1:0] t_com_dat;
  logic [3:0]             t_com_req;
  logic [3:0]             t_com_ack;
  logic [WORD_W-1:0]      i_com_dat;
  logic [3:0]             i_com_req;
  logic [3:0]             i_com_ack;

  int n_chk = 0;
  int n_err = 0;

  hornet_port_ctl dut (
    .clk       (clk),
    .reset     (reset),
    .core_req  (core_req),
    .core_we   (core_we),
    .core_mask (core_mask),
    .core_wdat (core_wdat),
    .core_rdat (core_rdat),
    .core_done (core_done),
    .core_busy (core_busy),
    .t_com_dat (t_com_dat),
    .t_com_req (t_com_req),
    .t_com_ack (t_com_ack),
    .i_com_dat (i_com_dat),
    .i_com_req (i_com_req),
    .i_com_ack (i_com_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle 1ns so sampling/driving is away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle core_req; returns positioned in cycle k+1.
  task automatic start(input logic we, input logic [3:0] mask, input logic [WORD_W-1:0] wdat);
    core_req  = 1'b1;
    core_we   = we;
    core_mask = mask;
    core_wdat = wdat;
    tick();
    core_req  = 1'b0;
    core_wdat = '0;
  endtask

  initial begin
    reset     = 1'b1;
    core_req  = 1'b0;
    core_we   = 1'b0;
    core_mask = '0;
    core_wdat = '0;
    t_com_dat = '0;
    t_com_req = '0;
    i_com_ack = '0;
    tick();
    tick();
    chk("rst_done", 32'(core_done), 32'h0);
    chk("rst_busy", 32'(core_busy), 32'h0);
    chk("rst_rdat", 32'(core_rdat), 32'h0);
    chk("rst_tack", 32'(t_com_ack), 32'h0);
    chk("rst_ireq", 32'(i_com_req), 32'h0);
    chk("rst_idat", 32'(i_com_dat), 32'h0);
    reset = 1'b0;
    tick();

    // Round-robin: all ports offering, grants N,S,W,E.
    t_com_req = 4'b1111;
    for (int p = 0; p < 4; p++) t_com_dat[p] = WORD_W'(32'h100 + p);
    for (int p = 0; p < 4; p++) begin
      start(1'b0, 4'b1111, '0);
      chk($sformatf("rr%0d_ack", p), 32'(t_com_ack), 32'(4'b0001 << p));
      chk($sformatf("rr%0d_busy", p), 32'(core_busy), 32'h1);
      tick();
      chk($sformatf("rr%0d_done", p), 32'(core_done), 32'h1);
      chk($sformatf("rr%0d_rdat", p), 32'(core_rdat), 32'h100 + p);
      chk($sformatf("rr%0d_tack0", p), 32'(t_com_ack), 32'h0);
      tick();
      chk($sformatf("rr%0d_done_off", p), 32'(core_done), 32'h0);
      chk($sformatf("rr%0d_idle", p), 32'(core_busy), 32'h0);
    end

    // Single read from W.
    t_com_req    = 4'b0100;
    t_com_dat    = '0;
    t_com_dat[2] = 18'h2AAAA;
    start(1'b0, 4'b1111, '0);
    chk("rd_ack", 32'(t_com_ack), 32'h4);
    chk("rd_done_k1", 32'(core_done), 32'h0);
    tick();
    chk("rd_done", 32'(core_done), 32'h1);
    chk("rd_rdat", 32'(core_rdat), 32'h2AAAA);
    tick();
    chk("rd_done_off", 32'(core_done), 32'h0);
    t_com_req = '0;

    // Write to n,s with a delayed ack; a stray core_req and unselected acks
    // in the middle must not disturb it.
    start(1'b1, 4'b0011, 18'h15555);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("wr_ireq%0d", c), 32'(i_com_req), 32'h3);
      chk($sformatf("wr_idat%0d", c), 32'(i_com_dat), 32'h15555);
      chk($sformatf("wr_done%0d", c), 32'(core_done), 32'h0);
      if (c == 2) begin
        core_req = 1'b1; core_we = 1'b0; core_mask = 4'b1111;
      end else begin
        core_req = 1'b0;
      end
      if (c == 4) i_com_ack = 4'b1100;
      tick();
    end
    core_req = 1'b0;
    chk("wr_unsel_ireq", 32'(i_com_req), 32'h3);
    chk("wr_unsel_done", 32'(core_done), 32'h0);
    i_com_ack = 4'b0001;
    tick();
    i_com_ack = 4'b0000;
    chk("wr_done", 32'(core_done), 32'h1);
    chk("wr_ireq_off", 32'(i_com_req), 32'h0);
    chk("wr_idat_off", 32'(i_com_dat), 32'h0);
    tick();
    chk("wr_done_once", 32'(core_done), 32'h0);
    chk("wr_idle", 32'(core_busy), 32'h0);
    tick();
    chk("wr_no_extra", 32'(core_done), 32'h0);

    // Filtering: only n selected, others offering -> never acked.
    t_com_req    = 4'b1110;
    t_com_dat[0] = 18'h0ABCD;
    start(1'b0, 4'b0001, '0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("flt_ack%0d", c), 32'(t_com_ack), 32'h0);
      chk($sformatf("flt_busy%0d", c), 32'(core_busy), 32'h1);
      chk($sformatf("flt_done%0d", c), 32'(core_done), 32'h0);
      tick();
    end
    t_com_req = 4'b1111;
    #1;
    chk("flt_ack", 32'(t_com_ack), 32'h1);
    tick();
    chk("flt_done", 32'(core_done), 32'h1);
    chk("flt_rdat", 32'(core_rdat), 32'h0ABCD);
    tick();

    // Empty-mask read: done at k+2 with zero data, no port touched.
    start(1'b0, 4'b0000, '0);
    chk("m0_done_k1", 32'(core_done), 32'h0);
    chk("m0_busy_k1", 32'(core_busy), 32'h1);
    chk("m0_tack", 32'(t_com_ack), 32'h0);
    tick();
    chk("m0_done", 32'(core_done), 32'h1);
    chk("m0_rdat", 32'(core_rdat), 32'h0);
    tick();
    chk("m0_done_off", 32'(core_done), 32'h0);
    chk("m0_idle", 32'(core_busy), 32'h0);
    t_com_req = '0;

    // Reset during WR_WAIT, with an ack arriving in the same cycle.
    start(1'b1, 4'b0011, 18'h3FFFF);
    chk("wrst_ireq_pre", 32'(i_com_req), 32'h3);
    reset     = 1'b1;
    i_com_ack = 4'b0001;
    #1;
    chk("wrst_ireq_now", 32'(i_com_req), 32'h0);
    chk("wrst_idat_now", 32'(i_com_dat), 32'h0);
    tick();
    chk("wrst_done", 32'(core_done), 32'h0);
    chk("wrst_busy", 32'(core_busy), 32'h0);
    reset     = 1'b0;
    i_com_ack = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("wrst_nodone%0d", c), 32'(core_done), 32'h0);
      chk($sformatf("wrst_noreq%0d", c), 32'(i_com_req), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
